// File: rtl/ospi_flash_ctrl_pkg.sv
// Shared types and constants for the OSPI flash sequencer.
// Optional feature macro: OSPI_FLASH_CTRL_VERIFY_EN (adds write/erase readback states).
package ospi_flash_ctrl_pkg;

  localparam int unsigned OP_W = 2;
  localparam logic [7:0]  ERASED_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_CAPTURE  = 3'd3,
`ifdef OSPI_FLASH_CTRL_VERIFY_EN
    ST_VEXEC    = 3'd4,
    ST_VCAPTURE = 3'd5,
`endif
    ST_HOLD     = 3'd6
  } state_e;

  // Index width for a vector of n entries; never zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ospi_flash_ctrl_if.sv
// Requester-side bus of the OSPI flash sequencer.
// master: requester view (drives req_valid/op/addr/wdata).
// slave : controller view (drives req_ready, rsp_valid/rdata/err, busy).
interface ospi_flash_ctrl_if
  import ospi_flash_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [OP_W*NUM_REQ-1:0]   req_op;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/ospi_rr_arbiter.sv
// Round-robin arbiter: the first valid requester at or after ptr wins.
// Ports: valid (request vector), ptr (highest-priority index),
//        grant (one-hot or zero), winner (index of the granted requester).
module ospi_rr_arbiter
  import ospi_flash_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  // Scan NUM_REQ candidates starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin : arb
    int unsigned       cand;
    logic              found;
    logic [NUM_REQ-1:0] sel;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    sel    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      sel = valid >> cand;
      if (!found && sel[0]) begin
        found  = 1'b1;
        grant  = NUM_REQ'(1) << cand;
        winner = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ospi_flash_ctrl.sv
// Arbitrating sequencer for a byte-wide OSPI flash. Grants single-byte
// READ/WRITE/ERASE requests round-robin and runs each through a fixed
// SETUP/EXEC/CAPTURE/HOLD sequence on the flash pins.
// Ports: clk, reset (sync, active high); bus (requester handshake, slave view);
//        flash_* pins (cs_n, strobes, address, write data, registered read data).
// Optional: OSPI_FLASH_CTRL_VERIFY_EN adds VEXEC/VCAPTURE readback for WRITE/ERASE.
module ospi_flash_ctrl
  import ospi_flash_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  ospi_flash_ctrl_if.slave  bus,
  output logic              flash_cs_n,
  output logic              flash_write_enable,
  output logic              flash_read_enable,
  output logic              flash_erase_enable,
  output logic [ADDR_W-1:0] flash_address,
  output logic [DATA_W-1:0] flash_data_in,
  input  logic [DATA_W-1:0] flash_data_out
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(CS_HIGH_CYCLES + 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                flash_cs_n_q, flash_cs_n_d;
  logic                flash_we_q, flash_we_d;
  logic                flash_re_q, flash_re_d;
  logic                flash_ee_q, flash_ee_d;
  logic [ADDR_W-1:0]   flash_address_q, flash_address_d;
  logic [DATA_W-1:0]   flash_data_in_q, flash_data_in_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    winner;
  logic                accept;
  logic [OP_W-1:0]     win_op;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  ospi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid  (bus.req_valid),
    .ptr    (rr_ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  // Ready is only offered from IDLE, one-hot to the arbiter winner.
  assign bus.req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign accept        = (state_q == ST_IDLE) && (|bus.req_valid);

  // Select the winner's payload through the one-hot grant.
  always_comb begin
    win_op    = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_op    |= bus.req_op[i*OP_W +: OP_W];
        win_addr  |= bus.req_addr[i*ADDR_W +: ADDR_W];
        win_wdata |= bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state, latched command and response data.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    hold_cnt_d      = hold_cnt_q;
    flash_address_d = flash_address_q;
    flash_data_in_d = flash_data_in_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d         = ST_SETUP;
          op_d            = op_e'(win_op);
          owner_d         = winner;
          flash_address_d = win_addr;
          flash_data_in_d = win_wdata;
          rr_ptr_d        = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
      end
      ST_SETUP: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        rsp_rdata_d = flash_data_out;
        rsp_err_d   = (op_q == OP_RSVD);
        state_d     = ST_HOLD;
        hold_cnt_d  = '0;
`ifdef OSPI_FLASH_CTRL_VERIFY_EN
        if (op_q == OP_WRITE || op_q == OP_ERASE) state_d = ST_VEXEC;
`endif
      end
`ifdef OSPI_FLASH_CTRL_VERIFY_EN
      ST_VEXEC: state_d = ST_VCAPTURE;
      ST_VCAPTURE: begin
        // Readback must equal the written byte, or the erased value.
        rsp_rdata_d = flash_data_out;
        rsp_err_d   = (op_q == OP_ERASE) ? (flash_data_out != DATA_W'(ERASED_BYTE))
                                         : (flash_data_out != flash_data_in_q);
        state_d     = ST_HOLD;
        hold_cnt_d  = '0;
      end
`endif
      ST_HOLD: begin
        if (hold_cnt_q == CNT_W'(CS_HIGH_CYCLES - 1)) state_d = ST_IDLE;
        else hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin values are registered, so they follow the state being entered.
    flash_cs_n_d = 1'b1;
    flash_we_d   = 1'b0;
    flash_re_d   = 1'b0;
    flash_ee_d   = 1'b0;
    rsp_valid_d  = '0;
    case (state_d)
      ST_SETUP, ST_CAPTURE: flash_cs_n_d = 1'b0;
      ST_EXEC: begin
        flash_cs_n_d = 1'b0;
        flash_we_d   = (op_q == OP_WRITE);
        flash_re_d   = (op_q == OP_READ);
        flash_ee_d   = (op_q == OP_ERASE);
      end
`ifdef OSPI_FLASH_CTRL_VERIFY_EN
      ST_VEXEC: begin
        flash_cs_n_d = 1'b0;
        flash_re_d   = 1'b1;
      end
      ST_VCAPTURE: flash_cs_n_d = 1'b0;
`endif
      ST_HOLD: begin
        if (state_q != ST_HOLD) rsp_valid_d = NUM_REQ'(1) << owner_q;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      op_q            <= OP_READ;
      owner_q         <= '0;
      rr_ptr_q        <= '0;
      hold_cnt_q      <= '0;
      flash_cs_n_q    <= 1'b1;
      flash_we_q      <= 1'b0;
      flash_re_q      <= 1'b0;
      flash_ee_q      <= 1'b0;
      flash_address_q <= '0;
      flash_data_in_q <= '0;
      rsp_valid_q     <= '0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      owner_q         <= owner_d;
      rr_ptr_q        <= rr_ptr_d;
      hold_cnt_q      <= hold_cnt_d;
      flash_cs_n_q    <= flash_cs_n_d;
      flash_we_q      <= flash_we_d;
      flash_re_q      <= flash_re_d;
      flash_ee_q      <= flash_ee_d;
      flash_address_q <= flash_address_d;
      flash_data_in_q <= flash_data_in_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      busy_q          <= busy_d;
    end
  end

  assign flash_cs_n         = flash_cs_n_q;
  assign flash_write_enable = flash_we_q;
  assign flash_read_enable  = flash_re_q;
  assign flash_erase_enable = flash_ee_q;
  assign flash_address      = flash_address_q;
  assign flash_data_in      = flash_data_in_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Directed testbench for ospi_flash_ctrl with a behavioural 256-byte flash.
module tb_ospi_flash_ctrl;
  import ospi_flash_ctrl_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CS_HIGH = 2;

  // Per-cycle traces: bit k is cycle T+k after the accept cycle T.
`ifdef OSPI_FLASH_CTRL_VERIFY_EN
  localparam logic [15:0] WR_CS_EXP   = 16'h003E;
  localparam logic [15:0] WR_RE_EXP   = 16'h0010;
  localparam logic [15:0] WR_RV_EXP   = 16'h0040;
  localparam logic [15:0] WR_BUSY_EXP = 16'h00FE;
  localparam logic        STUB_ERR    = 1'b1;
`else
  localparam logic [15:0] WR_CS_EXP   = 16'h000E;
  localparam logic [15:0] WR_RE_EXP   = 16'h0000;
  localparam logic [15:0] WR_RV_EXP   = 16'h0010;
  localparam logic [15:0] WR_BUSY_EXP = 16'h003E;
  localparam logic        STUB_ERR    = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flash_cs_n, flash_write_enable, flash_read_enable, flash_erase_enable;
  logic [ADDR_W-1:0] flash_address;
  logic [DATA_W-1:0] flash_data_in;
  logic [DATA_W-1:0] flash_data_out = 8'h00;
  logic [7:0]        mem [256];
  logic              stub_zero = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_multi = 0;

  logic [15:0] cs_tr, we_tr, re_tr, ee_tr, rv_tr, oth_tr, busy_tr;
  logic [7:0]  got_rdata, addr_setup, din_setup;
  logic        got_err, got_rsp, issue_ok;
  int          t_acc;

  ospi_flash_ctrl_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ospi_flash_ctrl #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CS_HIGH_CYCLES(CS_HIGH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .flash_cs_n         (flash_cs_n),
    .flash_write_enable (flash_write_enable),
    .flash_read_enable  (flash_read_enable),
    .flash_erase_enable (flash_erase_enable),
    .flash_address      (flash_address),
    .flash_data_in      (flash_data_in),
    .flash_data_out     (flash_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: commits on the edge ending the strobe cycle; data_out registered.
  always @(posedge clk) begin
    if (!flash_cs_n) begin
      if (flash_write_enable) mem[flash_address] <= flash_data_in;
      if (flash_erase_enable) mem[flash_address] <= 8'hFF;
      if (flash_read_enable)  flash_data_out <= stub_zero ? 8'h00 : mem[flash_address];
    end
  end

  always @(negedge clk)
    if ($countones({flash_write_enable, flash_read_enable, flash_erase_enable}) > 1)
      n_multi <= n_multi + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "timeout");
  end

  // Present a request and wait (bounded) for its accept; returns at T+1 +1ns.
  task automatic issue(input int r, input logic [1:0] op, input logic [7:0] addr,
                       input logic [7:0] wd);
    bus.req_op[r*2 +: 2]    = op;
    bus.req_addr[r*8 +: 8]  = addr;
    bus.req_wdata[r*8 +: 8] = wd;
    bus.req_valid[r]        = 1'b1;
    issue_ok = 1'b0;
    for (int w = 0; w < 50 && !issue_ok; w++) begin
      #1;
      if (bus.req_ready[r]) issue_ok = 1'b1;
      t_acc = cyc;
      @(posedge clk);
      #1;
    end
    bus.req_valid[r] = 1'b0;
    if (!issue_ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout req=%0d never got ready", r);
    end
  endtask

  // Issue one op and record pin/response traces for cycles T+1..T+12.
  task automatic run_op(input int r, input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wd);
    cs_tr = '0; we_tr = '0; re_tr = '0; ee_tr = '0; rv_tr = '0; oth_tr = '0; busy_tr = '0;
    got_rdata = 8'hxx; got_err = 1'bx; got_rsp = 1'b0;
    issue(r, op, addr, wd);
    if (!issue_ok) return;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        addr_setup = flash_address;
        din_setup  = flash_data_in;
      end
      cs_tr[k]   = !flash_cs_n;
      we_tr[k]   = flash_write_enable;
      re_tr[k]   = flash_read_enable;
      ee_tr[k]   = flash_erase_enable;
      rv_tr[k]   = bus.rsp_valid[r];
      oth_tr[k]  = |(bus.rsp_valid & ~(NUM_REQ'(1) << r));
      busy_tr[k] = bus.busy;
      if (bus.rsp_valid[r] && !got_rsp) begin
        got_rsp   = 1'b1;
        got_rdata = bus.rsp_rdata;
        got_err   = bus.rsp_err;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (flash_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n got %b exp 1", flash_cs_n); end
    n_tests++; if ({flash_write_enable, flash_read_enable, flash_erase_enable} !== 3'b000) begin
      n_fail++; $display("FAIL rst_strobes got %b exp 000",
                         {flash_write_enable, flash_read_enable, flash_erase_enable}); end
    n_tests++; if (flash_address !== 8'h00) begin n_fail++; $display("FAIL rst_addr got %h exp 00", flash_address); end
    n_tests++; if (flash_data_in !== 8'h00) begin n_fail++; $display("FAIL rst_din got %h exp 00", flash_data_in); end
    n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp 00", bus.rsp_valid); end
    n_tests++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h exp 00", bus.rsp_rdata); end
    n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.rsp_err); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b exp 00", bus.req_ready); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4];
    logic [1:0] got_g [4];
    int         t_g   [4];
    int         n = 0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    bus.req_op    = {OP_READ, OP_READ};
    bus.req_addr  = {8'h20, 8'h10};
    bus.req_valid = 2'b11;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        got_g[n] = bus.req_ready;
        t_g[n]   = cyc;
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
    n_tests++;
    if (n != 4) begin
      n_fail++; $display("FAIL b2b_count got %0d accepts exp 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got_g[i] !== exp_g[i]) begin
          n_fail++; $display("FAIL b2b_grant%0d got %b exp %b", i, got_g[i], exp_g[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_tests++;
        if (t_g[i] - t_g[i-1] != 6) begin
          n_fail++; $display("FAIL b2b_period%0d got %0d exp 6", i, t_g[i] - t_g[i-1]);
        end
      end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    run_op(0, OP_WRITE, 8'h10, 8'hA5);
    n_tests++; if (we_tr !== 16'h0004) begin n_fail++; $display("FAIL wr_we_trace got %h exp 0004", we_tr); end
    n_tests++; if (cs_tr !== WR_CS_EXP) begin n_fail++; $display("FAIL wr_cs_trace got %h exp %h", cs_tr, WR_CS_EXP); end
    n_tests++; if (re_tr !== WR_RE_EXP) begin n_fail++; $display("FAIL wr_re_trace got %h exp %h", re_tr, WR_RE_EXP); end
    n_tests++; if (rv_tr !== WR_RV_EXP) begin n_fail++; $display("FAIL wr_rv_trace got %h exp %h", rv_tr, WR_RV_EXP); end
    n_tests++; if (busy_tr !== WR_BUSY_EXP) begin n_fail++; $display("FAIL wr_busy_trace got %h exp %h", busy_tr, WR_BUSY_EXP); end
    n_tests++; if ({addr_setup, din_setup} !== 16'h10A5) begin
      n_fail++; $display("FAIL wr_setup_pins got %h/%h exp 10/A5", addr_setup, din_setup); end
    n_tests++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b exp 0", got_err); end

    run_op(0, OP_READ, 8'h10, 8'h00);
    n_tests++; if (re_tr !== 16'h0004) begin n_fail++; $display("FAIL rd_re_trace got %h exp 0004", re_tr); end
    n_tests++; if ((we_tr | ee_tr) !== 16'h0000) begin n_fail++; $display("FAIL rd_other_strobes got %h exp 0000", we_tr | ee_tr); end
    n_tests++; if (rv_tr !== 16'h0010) begin n_fail++; $display("FAIL rd_rv_trace got %h exp 0010", rv_tr); end
    n_tests++; if (oth_tr !== 16'h0000) begin n_fail++; $display("FAIL rd_other_rsp got %h exp 0000", oth_tr); end
    n_tests++; if (busy_tr !== 16'h003E) begin n_fail++; $display("FAIL rd_busy_trace got %h exp 003e", busy_tr); end
    n_tests++; if (got_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data got %h exp a5", got_rdata); end
    n_tests++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b exp 0", got_err); end
  endtask

  task automatic test_erase();
    run_op(0, OP_WRITE, 8'h20, 8'h3C);
    run_op(0, OP_READ, 8'h20, 8'h00);
    n_tests++; if (got_rdata !== 8'h3C) begin n_fail++; $display("FAIL er_prewrite got %h exp 3c", got_rdata); end
    run_op(0, OP_ERASE, 8'h20, 8'h00);
    n_tests++; if (ee_tr !== 16'h0004) begin n_fail++; $display("FAIL er_ee_trace got %h exp 0004", ee_tr); end
    n_tests++; if (we_tr !== 16'h0000) begin n_fail++; $display("FAIL er_we_trace got %h exp 0000", we_tr); end
    n_tests++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL er_err got %b exp 0", got_err); end
    run_op(0, OP_READ, 8'h20, 8'h00);
    n_tests++; if (got_rdata !== 8'hFF) begin n_fail++; $display("FAIL er_readback got %h exp ff", got_rdata); end
  endtask

  task automatic test_reserved();
    run_op(1, OP_RSVD, 8'h40, 8'h77);
    n_tests++; if ((we_tr | re_tr | ee_tr) !== 16'h0000) begin
      n_fail++; $display("FAIL rsv_strobes got %h exp 0000", we_tr | re_tr | ee_tr); end
    n_tests++; if (cs_tr !== 16'h000E) begin n_fail++; $display("FAIL rsv_cs_trace got %h exp 000e", cs_tr); end
    n_tests++; if (rv_tr !== 16'h0010) begin n_fail++; $display("FAIL rsv_rv_trace got %h exp 0010", rv_tr); end
    n_tests++; if (oth_tr !== 16'h0000) begin n_fail++; $display("FAIL rsv_other_rsp got %h exp 0000", oth_tr); end
    n_tests++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got %b exp 1", got_err); end
  endtask

  task automatic test_reset_mid();
    logic seen_rv = 1'b0;
    issue(0, OP_READ, 8'h10, 8'h00);
    if (!issue_ok) return;
    repeat (2) begin @(posedge clk); #1; end
    n_tests++; if (flash_cs_n !== 1'b0) begin n_fail++; $display("FAIL mid_capture_cs got %b exp 0", flash_cs_n); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++; if (flash_cs_n !== 1'b1) begin n_fail++; $display("FAIL mid_cs_n got %b exp 1", flash_cs_n); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
    for (int k = 0; k < 6; k++) begin
      seen_rv |= |bus.rsp_valid;
      @(posedge clk);
      #1;
    end
    n_tests++; if (seen_rv !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got %b exp 0", seen_rv); end
    bus.req_op    = {OP_READ, OP_READ};
    bus.req_addr  = {8'h20, 8'h10};
    bus.req_valid = 2'b11;
    #1;
    n_tests++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_ptr_reset got %b exp 01", bus.req_ready); end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_verify();
    stub_zero = 1'b1;
    run_op(0, OP_WRITE, 8'h30, 8'h5A);
    stub_zero = 1'b0;
    n_tests++; if (rv_tr !== WR_RV_EXP) begin n_fail++; $display("FAIL vfy_rv_trace got %h exp %h", rv_tr, WR_RV_EXP); end
    n_tests++; if (we_tr !== 16'h0004) begin n_fail++; $display("FAIL vfy_we_trace got %h exp 0004", we_tr); end
    n_tests++; if (re_tr !== WR_RE_EXP) begin n_fail++; $display("FAIL vfy_re_trace got %h exp %h", re_tr, WR_RE_EXP); end
    n_tests++; if (got_err !== STUB_ERR) begin n_fail++; $display("FAIL vfy_err got %b exp %b", got_err, STUB_ERR); end
`ifdef OSPI_FLASH_CTRL_VERIFY_EN
    n_tests++; if (got_rdata !== 8'h00) begin n_fail++; $display("FAIL vfy_rdata got %h exp 00", got_rdata); end
`endif
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_back_to_back();
    test_write_read();
    test_erase();
    test_reserved();
    test_reset_mid();
    test_verify();
    n_tests++;
    if (n_multi !== 0) begin n_fail++; $display("FAIL multi_strobe got %0d cycles exp 0", n_multi); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
